// File: rtl/hci_bank_starvation_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : hci_bank_starvation_ctrl_pkg
// Brief   : Shared types and constants for the per-bank starvation scheduler.
// Revision: 1.0 - initial release
// ============================================================================
package hci_bank_starvation_ctrl_pkg;

    // Default configuration field width.
    localparam int HCI_CW = 8;

    // Reset-time suggestion for the stall threshold, for integrators.
    localparam int HCI_DEFAULT_MAX_STALL = 8;

    // Per-bank scheduler state, explicitly encoded.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BOOST = 2'd1,
        COOL  = 2'd2
    } hci_starve_state_t;

    // Runtime configuration bundle.
    typedef struct packed {
        logic [HCI_CW-1:0] max_stall;
        logic [HCI_CW-1:0] boost_len;
    } hci_starve_cfg_t;

endpackage
`default_nettype wire

// File: rtl/hci_bank_starvation_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module  : hci_bank_starvation_fsm
// Brief   : Single-bank IDLE/BOOST/COOL scheduler with a shared stall/grant
//           counter; drives the registered priority-inversion bit.
// Revision: 1.0 - initial release
// ============================================================================
module hci_bank_starvation_fsm
    import hci_bank_starvation_ctrl_pkg::*;
#(
    parameter int CW = HCI_CW
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          clear_i,
    input  logic          enable_i,
    input  logic [CW-1:0] max_stall_i,
    input  logic [CW-1:0] boost_len_i,
    input  logic          hi_req_i,
    input  logic          lo_req_i,
    input  logic          lo_gnt_i,
    output logic          invert_prio_o,
    output logic          invert_nxt_o,
    output logic          enter_boost_o
);

    hci_starve_state_t r_state;
    hci_starve_state_t w_state_nxt;
    logic [CW-1:0]     r_cnt;
    logic [CW-1:0]     w_cnt_nxt;
    logic              r_invert;
    logic              w_enter;

    logic              w_stall;
    logic [CW-1:0]     w_ms_m1;
    logic [CW-1:0]     w_len_m1;
    logic              w_stall_hit;
    logic              w_len_hit;

    // Stalls only matter when both sides want the bank and the low side lost.
    assign w_stall  = hi_req_i & lo_req_i & ~lo_gnt_i;
    assign w_ms_m1  = max_stall_i - CW'(1);
    // A zero boost length behaves as one grant per boost.
    assign w_len_m1 = (boost_len_i == '0) ? '0 : (boost_len_i - CW'(1));
    // Using >= lets a shrunk config take effect even if cnt is already past it.
    assign w_stall_hit = (max_stall_i != '0) && (r_cnt >= w_ms_m1);
    assign w_len_hit   = (r_cnt >= w_len_m1);

    // Next-state and counter update; disable overrides everything.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_enter     = 1'b0;
        if (!enable_i) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_stall) begin
                        if (w_stall_hit) begin
                            w_state_nxt = BOOST;
                            w_cnt_nxt   = '0;
                            w_enter     = 1'b1;
                        end else begin
                            w_cnt_nxt = r_cnt + CW'(1);
                        end
                    end else begin
                        w_cnt_nxt = '0;
                    end
                end
                BOOST: begin
                    // Leave when the HWPE stream ends or the grant budget is spent.
                    if (!lo_req_i || (lo_gnt_i && w_len_hit)) begin
                        w_state_nxt = COOL;
                        w_cnt_nxt   = '0;
                    end else if (lo_gnt_i) begin
                        w_cnt_nxt = r_cnt + CW'(1);
                    end
                end
                COOL: begin
                    // One guaranteed slot for the high side between boosts.
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    // State, counter and registered inversion bit.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_invert <= 1'b0;
        end else if (clear_i) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_invert <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_invert <= (w_state_nxt == BOOST);
        end
    end

    assign invert_prio_o = r_invert;
    assign invert_nxt_o  = (w_state_nxt == BOOST);
    assign enter_boost_o = w_enter;

endmodule
`default_nettype wire

// File: rtl/hci_bank_starvation_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : hci_bank_starvation_ctrl
// Brief   : Per-bank priority-inversion scheduler for shared TCDM banks; one
//           FSM per bank plus a saturating starvation-event counter.
// Revision: 1.0 - initial release
// ============================================================================
module hci_bank_starvation_ctrl
    import hci_bank_starvation_ctrl_pkg::*;
#(
    parameter int N_MEM = 16,
    parameter int CW    = HCI_CW,
    parameter int EW    = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             enable_i,
    input  logic [CW-1:0]    max_stall_i,
    input  logic [CW-1:0]    boost_len_i,
    input  logic [N_MEM-1:0] hi_req_i,
    input  logic [N_MEM-1:0] lo_req_i,
    input  logic [N_MEM-1:0] lo_gnt_i,
    output logic [N_MEM-1:0] invert_prio_o,
    output logic             boost_active_o,
    output logic [EW-1:0]    starve_evt_o
);

    localparam int PW = $clog2(N_MEM + 1);
    localparam int SW = ((EW > PW) ? EW : PW) + 1;
    localparam logic [EW-1:0] c_EVT_MAX = '1;

    logic [N_MEM-1:0] w_inv_nxt;
    logic [N_MEM-1:0] w_enter;
    logic [PW-1:0]    w_pop;
    logic [SW-1:0]    w_sum;
    logic [EW-1:0]    w_evt_nxt;
    logic [EW-1:0]    r_evt;
    logic             r_boost_active;

    generate
        for (genvar g = 0; g < N_MEM; g++) begin : g_bank
            hci_bank_starvation_fsm #(
                .CW (CW)
            ) u_fsm (
                .clk_i         (clk_i),
                .rst_ni        (rst_ni),
                .clear_i       (clear_i),
                .enable_i      (enable_i),
                .max_stall_i   (max_stall_i),
                .boost_len_i   (boost_len_i),
                .hi_req_i      (hi_req_i[g]),
                .lo_req_i      (lo_req_i[g]),
                .lo_gnt_i      (lo_gnt_i[g]),
                .invert_prio_o (invert_prio_o[g]),
                .invert_nxt_o  (w_inv_nxt[g]),
                .enter_boost_o (w_enter[g])
            );
        end
    endgenerate

    // Count banks entering BOOST this cycle.
    always_comb begin
        w_pop = '0;
        for (int i = 0; i < N_MEM; i++) begin
            w_pop = w_pop + PW'(w_enter[i]);
        end
    end

    // Saturating accumulation; the sum is wide enough never to wrap itself.
    assign w_sum     = SW'(r_evt) + SW'(w_pop);
    assign w_evt_nxt = (w_sum > SW'(c_EVT_MAX)) ? c_EVT_MAX : w_sum[EW-1:0];

    // Event counter and aggregate boost flag, aligned with the invert bits.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_evt          <= '0;
            r_boost_active <= 1'b0;
        end else if (clear_i) begin
            r_evt          <= '0;
            r_boost_active <= 1'b0;
        end else begin
            r_evt          <= w_evt_nxt;
            r_boost_active <= |w_inv_nxt;
        end
    end

    assign starve_evt_o   = r_evt;
    assign boost_active_o = r_boost_active;

endmodule
`default_nettype wire

// File: tb/tb_hci_bank_starvation_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_hci_bank_starvation_ctrl
// Brief   : Directed scoreboard bench for hci_bank_starvation_ctrl.
// Revision: 1.0 - initial release
// ============================================================================
module tb_hci_bank_starvation_ctrl;

    localparam int N_MEM = 16;
    localparam int CW    = 8;
    localparam int EW    = 4;
    localparam logic [15:0] B3  = 16'h0008;
    localparam logic [15:0] ALL = 16'hFFFF;
    localparam logic [15:0] NON = 16'h0000;

    logic             clk;
    logic             rst_ni;
    logic             clear_i;
    logic             enable_i;
    logic [CW-1:0]    max_stall_i;
    logic [CW-1:0]    boost_len_i;
    logic [N_MEM-1:0] hi_req_i;
    logic [N_MEM-1:0] lo_req_i;
    logic [N_MEM-1:0] lo_gnt_i;
    logic [N_MEM-1:0] invert_prio_o;
    logic             boost_active_o;
    logic [EW-1:0]    starve_evt_o;

    typedef struct {
        string       tag;
        logic [15:0] inv;
        logic        ba;
        logic [3:0]  evt;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;

    hci_bank_starvation_ctrl #(
        .N_MEM (N_MEM),
        .CW    (CW),
        .EW    (EW)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .clear_i        (clear_i),
        .enable_i       (enable_i),
        .max_stall_i    (max_stall_i),
        .boost_len_i    (boost_len_i),
        .hi_req_i       (hi_req_i),
        .lo_req_i       (lo_req_i),
        .lo_gnt_i       (lo_gnt_i),
        .invert_prio_o  (invert_prio_o),
        .boost_active_o (boost_active_o),
        .starve_evt_o   (starve_evt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record what the outputs must look like after the next sample point.
    task automatic push_exp(input string tag, input logic [15:0] inv, input logic [3:0] evt);
        exp_t e;
        e.tag = tag;
        e.inv = inv;
        e.ba  = |inv;
        e.evt = evt;
        sb_q.push_back(e);
    endtask

    // Pop the oldest expectation and compare all outputs against it.
    task automatic check_out();
        exp_t e;
        if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_empty observed=0 entries expected>=1");
            return;
        end
        e = sb_q.pop_front();
        checks++;
        assert (invert_prio_o === e.inv) else begin
            failures++;
            $error("FAIL %s invert_prio_o observed=%h expected=%h", e.tag, invert_prio_o, e.inv);
        end
        checks++;
        assert (boost_active_o === e.ba) else begin
            failures++;
            $error("FAIL %s boost_active_o observed=%b expected=%b", e.tag, boost_active_o, e.ba);
        end
        checks++;
        assert (starve_evt_o === e.evt) else begin
            failures++;
            $error("FAIL %s starve_evt_o observed=%0d expected=%0d", e.tag, starve_evt_o, e.evt);
        end
    endtask

    // Drive one cycle of requests, expect the registered result after the edge.
    task automatic step(input string tag, input logic [15:0] hi, input logic [15:0] lo,
                        input logic [15:0] gnt, input logic [15:0] inv, input logic [3:0] evt);
        hi_req_i = hi;
        lo_req_i = lo;
        lo_gnt_i = gnt;
        push_exp(tag, inv, evt);
        @(posedge clk);
        #1;
        check_out();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_ni      = 1'b0;
        clear_i     = 1'b0;
        enable_i    = 1'b1;
        max_stall_i = 8'd4;
        boost_len_i = 8'd2;
        hi_req_i    = '0;
        lo_req_i    = '0;
        lo_gnt_i    = '0;

        #12;
        push_exp("reset", NON, 4'd0);
        check_out();
        @(negedge clk);
        rst_ni = 1'b1;
        @(posedge clk);
        #1;

        // Four contended stalls on bank 3 trigger a boost.
        for (int i = 0; i < 3; i++) step("stall_pre", B3, B3, NON, NON, 4'd0);
        step("stall_thr", B3, B3, NON, B3, 4'd1);
        step("boost_g1", B3, B3, B3, B3, 4'd1);
        step("boost_g2", B3, B3, B3, NON, 4'd1);
        // COOL ignores stalls; counting restarts only in IDLE.
        step("cool_stall", B3, B3, NON, NON, 4'd1);
        for (int i = 0; i < 3; i++) step("restall", B3, B3, NON, NON, 4'd1);
        step("restall_thr", B3, B3, NON, B3, 4'd2);
        // HWPE stream ends before any grant.
        step("early_exit", B3, NON, NON, NON, 4'd2);
        step("post_cool", NON, NON, NON, NON, 4'd2);

        // Low side waiting without high-side contention never stalls.
        for (int i = 0; i < 100; i++) step("no_contention", NON, ALL, NON, NON, 4'd2);

        // A stall broken after three cycles restarts the count.
        for (int i = 0; i < 3; i++) step("broken_pre", B3, B3, NON, NON, 4'd2);
        step("broken_gap", NON, B3, NON, NON, 4'd2);
        for (int i = 0; i < 3; i++) step("broken_post", B3, B3, NON, NON, 4'd2);
        step("broken_thr", B3, B3, NON, B3, 4'd3);

        // Zero boost length means one grant.
        boost_len_i = 8'd0;
        step("len0_grant", B3, B3, B3, NON, 4'd3);
        step("len0_cool", NON, NON, NON, NON, 4'd3);

        // Zero threshold disables boosting.
        max_stall_i = 8'd0;
        for (int i = 0; i < 20; i++) step("ms0", ALL, ALL, NON, NON, 4'd3);
        step("ms0_idle", NON, NON, NON, NON, 4'd3);

        // Disable mid-boost and disable coinciding with threshold.
        max_stall_i = 8'd4;
        boost_len_i = 8'd2;
        for (int i = 0; i < 3; i++) step("en_pre", B3, B3, NON, NON, 4'd3);
        step("en_thr", B3, B3, NON, B3, 4'd4);
        enable_i = 1'b0;
        step("en_off", B3, B3, NON, NON, 4'd4);
        enable_i = 1'b1;
        for (int i = 0; i < 3; i++) step("en_re", B3, B3, NON, NON, 4'd4);
        enable_i = 1'b0;
        step("en_off_thr", B3, B3, NON, NON, 4'd4);
        enable_i = 1'b1;
        for (int i = 0; i < 3; i++) step("en_on", B3, B3, NON, NON, 4'd4);
        step("en_on_thr", B3, B3, NON, B3, 4'd5);

        // Synchronous clear while boosting.
        clear_i = 1'b1;
        step("clear", B3, B3, NON, NON, 4'd0);
        clear_i = 1'b0;
        step("post_clear", NON, NON, NON, NON, 4'd0);

        // All banks boost together: count saturates and never wraps.
        for (int i = 0; i < 3; i++) step("sat_pre", ALL, ALL, NON, NON, 4'd0);
        step("sat_thr", ALL, ALL, NON, ALL, 4'd15);
        step("sat_exit", ALL, NON, NON, NON, 4'd15);
        step("sat_idle", NON, NON, NON, NON, 4'd15);
        for (int i = 0; i < 3; i++) step("sat2_pre", ALL, ALL, NON, NON, 4'd15);
        step("sat2_thr", ALL, ALL, NON, ALL, 4'd15);

        // Asynchronous reset mid-boost takes effect without a clock edge.
        rst_ni = 1'b0;
        #1;
        push_exp("async_rst", NON, 4'd0);
        check_out();
        #2;
        rst_ni = 1'b1;
        step("post_rst", NON, NON, NON, NON, 4'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
